// File: rtl/dcache_mshr_file_pkg.sv
// Shared types for the D-cache MSHR file: bus message codes, entry state,
// the per-entry record and the default geometry.
package dcache_mshr_file_pkg;

    localparam int unsigned MSHR_DEPTH_DEF = 8;
    localparam int unsigned TAG_W_DEF      = 56;
    localparam int unsigned IDX_W_DEF      = 5;
    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned CPU_ID_W_DEF   = 1;
    localparam int unsigned MSHR_PTR_W     = $clog2(MSHR_DEPTH_DEF);

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        GET_S = 2'd1,
        GET_M = 2'd2,
        PUT_M = 2'd3
    } message_t;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2
    } mshr_state_t;

    // All-zero encodes a FREE entry with msg NONE.
    typedef struct packed {
        mshr_state_t             state;
        message_t                msg;
        logic                    inv;
        logic [TAG_W_DEF-1:0]    tag;
        logic [IDX_W_DEF-1:0]    idx;
        logic [DATA_W_DEF-1:0]   data;
    } mshr_entry_t;

endpackage

// File: rtl/mshr_idx_fifo.sv
// Circular FIFO of MSHR entry indices, giving bus issue in allocation order.
// Ports: push_i/push_idx_i enqueue, pop_i dequeues the head, head_o shows the
// oldest index, empty_o flags no queued entries. Depth equals the entry count,
// so it cannot overflow; pop is only requested when non-empty.
module mshr_idx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [PTR_W-1:0] push_idx_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] head_o,
    output logic             empty_o
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d = mem_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_idx_i;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        cnt_d    = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/dcache_mshr_file.sv
// Multi-entry miss status holding register file for the D-cache controller.
// Ports: alloc_* take a GET_S/GET_M miss (new entry or merge); iss_* present the
// oldest un-granted entry to the snooping bus; bus_req_* carry grants and
// snooped requests; rsp_* take entry-tagged out-of-order responses; fill_*
// write the line into the cache; lq_* look up pending lines for loads;
// protocol_err_o is sticky on a response to a non-waiting entry.
module dcache_mshr_file
    import dcache_mshr_file_pkg::*;
#(
    parameter  int unsigned MSHR_DEPTH = MSHR_DEPTH_DEF,
    parameter  int unsigned TAG_W      = TAG_W_DEF,
    parameter  int unsigned IDX_W      = IDX_W_DEF,
    parameter  int unsigned DATA_W     = DATA_W_DEF,
    parameter  int unsigned CPU_ID_W   = CPU_ID_W_DEF,
    localparam int unsigned PTR_W      = $clog2(MSHR_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CPU_ID_W-1:0] cpu_id_i,
    input  logic                alloc_en_i,
    input  logic [TAG_W-1:0]    alloc_tag_i,
    input  logic [IDX_W-1:0]    alloc_idx_i,
    input  logic [DATA_W-1:0]   alloc_data_i,
    input  message_t            alloc_msg_i,
    output logic                alloc_ack_o,
    output logic                alloc_merge_o,
    output logic                full_o,
    output logic                iss_en_o,
    output logic [TAG_W-1:0]    iss_tag_o,
    output logic [IDX_W-1:0]    iss_idx_o,
    output logic [DATA_W-1:0]   iss_data_o,
    output message_t            iss_msg_o,
    output logic [PTR_W-1:0]    iss_ptr_o,
    input  logic                bus_req_ack_i,
    input  logic [CPU_ID_W-1:0] bus_req_id_i,
    input  message_t            bus_req_msg_i,
    input  logic [TAG_W-1:0]    bus_req_tag_i,
    input  logic [IDX_W-1:0]    bus_req_idx_i,
    input  logic                rsp_vld_i,
    input  logic [CPU_ID_W-1:0] rsp_id_i,
    input  logic [PTR_W-1:0]    rsp_ptr_i,
    input  logic [DATA_W-1:0]   rsp_data_i,
    output logic                rsp_ack_o,
    input  logic                fill_stall_i,
    output logic                fill_en_o,
    output logic [TAG_W-1:0]    fill_tag_o,
    output logic [IDX_W-1:0]    fill_idx_o,
    output logic [DATA_W-1:0]   fill_data_o,
    output message_t            fill_msg_o,
    output logic                fill_inv_o,
    input  logic [TAG_W-1:0]    lq_tag_i,
    input  logic [IDX_W-1:0]    lq_idx_i,
    output logic                lq_hit_o,
    output logic                lq_fwd_vld_o,
    output logic [DATA_W-1:0]   lq_fwd_data_o,
    output logic                protocol_err_o
);

    mshr_entry_t      ent_q [MSHR_DEPTH];
    mshr_entry_t      ent_d [MSHR_DEPTH];
    logic             protocol_err_q, protocol_err_d;

    logic             fifo_push, fifo_pop, fifo_empty;
    logic [PTR_W-1:0] head;
    logic             grant, snoop_m, rsp_hit, rsp_wait, fill_acc;
    logic             hit, blocked, free_found, alloc_ok;
    logic [PTR_W-1:0] hit_idx, free_idx;

    mshr_idx_fifo #(
        .DEPTH (MSHR_DEPTH),
        .PTR_W (PTR_W)
    ) u_idx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_idx_i (free_idx),
        .pop_i      (fifo_pop),
        .head_o     (head),
        .empty_o    (fifo_empty)
    );

    // Issue, response/fill, lookup, snoop and allocation in one pass over the entries.
    always_comb begin
        ent_d          = ent_q;
        protocol_err_d = protocol_err_q;
        fifo_push      = 1'b0;
        alloc_ack_o    = 1'b0;
        alloc_merge_o  = 1'b0;
        full_o         = 1'b1;
        free_found     = 1'b0;
        free_idx       = '0;
        hit            = 1'b0;
        hit_idx        = '0;
        blocked        = 1'b0;
        lq_hit_o       = 1'b0;
        lq_fwd_vld_o   = 1'b0;
        lq_fwd_data_o  = '0;

        iss_en_o   = !fifo_empty;
        iss_tag_o  = iss_en_o ? ent_q[head].tag  : '0;
        iss_idx_o  = iss_en_o ? ent_q[head].idx  : '0;
        iss_data_o = iss_en_o ? ent_q[head].data : '0;
        iss_msg_o  = iss_en_o ? ent_q[head].msg  : NONE;
        iss_ptr_o  = iss_en_o ? head : '0;
        grant      = iss_en_o && bus_req_ack_i && (bus_req_id_i == cpu_id_i)
                     && (bus_req_msg_i == iss_msg_o);
        fifo_pop   = grant;
        snoop_m    = bus_req_ack_i && (bus_req_id_i != cpu_id_i) && (bus_req_msg_i == GET_M);

        rsp_hit     = rsp_vld_i && (rsp_id_i == cpu_id_i);
        rsp_wait    = (ent_q[rsp_ptr_i].state == WAIT);
        fill_acc    = rsp_hit && rsp_wait && !fill_stall_i;
        rsp_ack_o   = fill_acc || (rsp_hit && !rsp_wait);
        fill_en_o   = fill_acc;
        fill_tag_o  = fill_acc ? ent_q[rsp_ptr_i].tag : '0;
        fill_idx_o  = fill_acc ? ent_q[rsp_ptr_i].idx : '0;
        fill_msg_o  = fill_acc ? ent_q[rsp_ptr_i].msg : NONE;
        fill_inv_o  = fill_acc && ent_q[rsp_ptr_i].inv;
        fill_data_o = !fill_acc ? '0 :
                      (ent_q[rsp_ptr_i].msg == GET_M) ? ent_q[rsp_ptr_i].data : rsp_data_i;
        if (rsp_hit && !rsp_wait) begin
            protocol_err_d = 1'b1;
        end

        for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
            if (ent_q[i].state == FREE) begin
                full_o = 1'b0;
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = PTR_W'(i);
                end
            end else begin
                // An entry filled this cycle cannot absorb a merge; the requester retries.
                if (ent_q[i].tag == alloc_tag_i && ent_q[i].idx == alloc_idx_i) begin
                    if (fill_acc && rsp_ptr_i == PTR_W'(i)) begin
                        blocked = 1'b1;
                    end else begin
                        hit     = 1'b1;
                        hit_idx = PTR_W'(i);
                    end
                end
                if (ent_q[i].tag == lq_tag_i && ent_q[i].idx == lq_idx_i) begin
                    lq_hit_o = 1'b1;
                    if (ent_q[i].msg == GET_M) begin
                        lq_fwd_vld_o  = 1'b1;
                        lq_fwd_data_o = ent_q[i].data;
                    end
                end
                // Another CPU takes ownership while our shared copy is in flight.
                if (snoop_m && ent_q[i].state == WAIT && ent_q[i].msg == GET_S
                    && ent_q[i].tag == bus_req_tag_i && ent_q[i].idx == bus_req_idx_i) begin
                    ent_d[i].inv = 1'b1;
                end
            end
        end

        if (grant) begin
            ent_d[head].state = WAIT;
        end

        alloc_ok = alloc_en_i && !blocked && (alloc_msg_i == GET_S || alloc_msg_i == GET_M);
        if (alloc_ok && hit) begin
            if (alloc_msg_i == GET_S) begin
                alloc_ack_o   = 1'b1;
                alloc_merge_o = 1'b1;
            end else if (ent_q[hit_idx].state == PEND
                         && (ent_q[hit_idx].msg == GET_M || !(grant && head == hit_idx))) begin
                // Store merge or GET_S upgrade; an upgrade racing its own grant is refused.
                alloc_ack_o          = 1'b1;
                alloc_merge_o        = 1'b1;
                ent_d[hit_idx].msg   = GET_M;
                ent_d[hit_idx].data  = alloc_data_i;
            end
        end else if (alloc_ok && free_found) begin
            alloc_ack_o           = 1'b1;
            fifo_push             = 1'b1;
            ent_d[free_idx].state = PEND;
            ent_d[free_idx].msg   = alloc_msg_i;
            ent_d[free_idx].inv   = 1'b0;
            ent_d[free_idx].tag   = alloc_tag_i;
            ent_d[free_idx].idx   = alloc_idx_i;
            ent_d[free_idx].data  = (alloc_msg_i == GET_M) ? alloc_data_i : '0;
        end

        if (fill_acc) begin
            ent_d[rsp_ptr_i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            protocol_err_q <= 1'b0;
        end else begin
            ent_q          <= ent_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err_o = protocol_err_q;

endmodule
